// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential Booth multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Internal operand width: one guard bit so unsigned operands stay positive.
    function automatic int op_width(input int width);
        return width + 1;
    endfunction

    // Step counter must hold 0..W1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 2);
    endfunction

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth step: conditional add of A or S, then arithmetic shift right.
module booth_step #(
    parameter int PW = 67
) (
    input  logic [PW-1:0] p,
    input  logic [PW-1:0] a,
    input  logic [PW-1:0] s,
    output logic [PW-1:0] p_next
);

    logic [PW-1:0] sum;

    always_comb begin
        sum = p;
        unique case (p[1:0])
            2'b01:   sum = p + a;
            2'b10:   sum = p + s;
            default: sum = p;
        endcase
        p_next = {sum[PW-1], sum[PW-1:1]};
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed/unsigned, one step per clock.
module booth_mult_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    import mult_pkg::*;

    localparam int W1 = op_width(WIDTH);
    localparam int PW = 2 * W1 + 1;
    localparam int CW = cnt_width(WIDTH);

    state_t state;
    state_t state_next;

    logic [PW-1:0] p;
    logic [PW-1:0] a;
    logic [PW-1:0] s;
    logic [PW-1:0] p_next;
    logic [CW-1:0] cnt;
    logic [W1-1:0] m;
    logic [W1-1:0] m_neg;
    logic [W1-1:0] q;
    logic          accept;
    logic          last;

    // Sign- or zero-extend so both modes run through the same signed datapath.
    always_comb begin
        m = signed_mode ? {operand1[WIDTH-1], operand1}
                        : {1'b0, operand1};
        q = signed_mode ? {operand2[WIDTH-1], operand2}
                        : {1'b0, operand2};
        m_neg = ~m + W1'(1);
    end

    assign accept = start && (state != RUN);
    assign last   = (state == RUN) && (cnt == CW'(W1 - 1));
    assign busy   = (state == RUN);
    assign done   = (state == DONE);

    booth_step #(
        .PW(PW)
    ) u_step (
        .p      (p),
        .a      (a),
        .s      (s),
        .p_next (p_next)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p   <= '0;
            a   <= '0;
            s   <= '0;
            cnt <= '0;
            hi  <= '0;
            lo  <= '0;
        end else if (accept) begin
            a   <= {m, {(W1 + 1){1'b0}}};
            s   <= {m_neg, {(W1 + 1){1'b0}}};
            p   <= {{W1{1'b0}}, q, 1'b0};
            cnt <= '0;
        end else if (state == RUN) begin
            p   <= p_next;
            cnt <= cnt + CW'(1);
            if (last) begin
                hi <= p_next[2*WIDTH:WIDTH+1];
                lo <= p_next[WIDTH:1];
            end
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Randomised self-checking bench for booth_mult_seq at WIDTH=32 and WIDTH=8.
module tb_booth_mult_seq;

    logic        clk;
    logic        rst;

    logic        start32;
    logic        sm32;
    logic [31:0] a32;
    logic [31:0] b32;
    logic        busy32;
    logic        done32;
    logic [31:0] hi32;
    logic [31:0] lo32;

    logic        start8;
    logic        sm8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        done8;
    logic [7:0]  hi8;
    logic [7:0]  lo8;

    int tests;
    int fails;

    booth_mult_seq #(.WIDTH(32)) dut32 (
        .clock       (clk),
        .reset       (rst),
        .start       (start32),
        .signed_mode (sm32),
        .operand1    (a32),
        .operand2    (b32),
        .busy        (busy32),
        .done        (done32),
        .hi          (hi32),
        .lo          (lo32)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clock       (clk),
        .reset       (rst),
        .start       (start8),
        .signed_mode (sm8),
        .operand1    (a8),
        .operand2    (b8),
        .busy        (busy8),
        .done        (done8),
        .hi          (hi8),
        .lo          (lo8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mathematical product of two w-bit operands, low 2w bits.
    function automatic logic [63:0] ref_prod(input logic sm,
                                             input logic [31:0] x,
                                             input logic [31:0] y,
                                             input int w);
        longint ex;
        longint ey;
        longint mask;
        longint pr;
        mask = (longint'(1) << w) - 1;
        ex = longint'({32'b0, x}) & mask;
        ey = longint'({32'b0, y}) & mask;
        if (sm && ex[w-1]) ex = ex - (longint'(1) << w);
        if (sm && ey[w-1]) ey = ey - (longint'(1) << w);
        pr = ex * ey;
        if (w < 32) pr = pr & ((longint'(1) << (2 * w)) - 1);
        return 64'(pr);
    endfunction

    task automatic run32(input logic sm, input logic [31:0] x,
                         input logic [31:0] y, output int lat);
        @(negedge clk);
        sm32 = sm;
        a32 = x;
        b32 = y;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        a32 = $urandom;
        b32 = $urandom;
        sm32 = ~sm;
        lat = 0;
        while (!done32 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            start32 = (lat == 5);
            if (lat == 7) a32 = $urandom;
        end
        start32 = 1'b0;
    endtask

    task automatic run8(input logic sm, input logic [7:0] x,
                        input logic [7:0] y, output int lat);
        @(negedge clk);
        sm8 = sm;
        a8 = x;
        b8 = y;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        lat = 0;
        while (!done8 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic test_reset;
        @(posedge clk);
        #1;
        tests++;
        if ({busy32, done32, hi32, lo32} !== 66'b0) begin
            fails++;
            $display("FAIL reset32 got busy=%b done=%b hi=%h lo=%h want all 0",
                     busy32, done32, hi32, lo32);
        end
        tests++;
        if ({busy8, done8, hi8, lo8} !== 18'b0) begin
            fails++;
            $display("FAIL reset8 got busy=%b done=%b hi=%h lo=%h want all 0",
                     busy8, done8, hi8, lo8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        sm;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    task automatic test_corners;
        vec_t v[6];
        int lat;
        v[0] = '{1'b1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        v[1] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
        v[2] = '{1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0};
        v[3] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h1};
        v[4] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1};
        v[5] = '{1'b0, 32'd7, 32'hFFFFFFFD, 32'h6, 32'hFFFFFFEB};
        for (int i = 0; i < 6; i++) begin
            run32(v[i].sm, v[i].x, v[i].y, lat);
            tests++;
            if (lat !== 33) begin
                fails++;
                $display("FAIL corner%0d_latency got %0d want 33", i, lat);
            end
            tests++;
            if ({hi32, lo32} !== {v[i].hi, v[i].lo} || busy32 !== 1'b0) begin
                fails++;
                $display("FAIL corner%0d_product got %h_%h busy=%b want %h_%h busy=0",
                         i, hi32, lo32, busy32, v[i].hi, v[i].lo);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic        sms[4];
        logic [31:0] xs[4];
        logic [31:0] ys[4];
        logic [63:0] exp;
        int idx;
        int cyc;
        int guard;
        for (int i = 0; i < 4; i++) begin
            sms[i] = 1'($urandom);
            xs[i] = $urandom;
            ys[i] = $urandom;
        end
        @(negedge clk);
        sm32 = sms[0];
        a32 = xs[0];
        b32 = ys[0];
        start32 = 1'b1;
        @(posedge clk);
        #1;
        idx = 0;
        cyc = 0;
        guard = 0;
        while (idx < 4 && guard < 400) begin
            if (!done32) begin
                a32 = $urandom;
                b32 = $urandom;
                sm32 = 1'($urandom);
            end
            @(posedge clk);
            #1;
            cyc++;
            guard++;
            if (busy32 && done32) begin
                tests++;
                fails++;
                $display("FAIL b2b_overlap busy and done both high at cycle %0d", guard);
            end
            if (done32) begin
                exp = ref_prod(sms[idx], xs[idx], ys[idx], 32);
                tests++;
                if (cyc !== (idx == 0 ? 33 : 34)) begin
                    fails++;
                    $display("FAIL b2b%0d_interval got %0d want %0d",
                             idx, cyc, idx == 0 ? 33 : 34);
                end
                tests++;
                if ({hi32, lo32} !== exp) begin
                    fails++;
                    $display("FAIL b2b%0d_product got %h_%h want %h",
                             idx, hi32, lo32, exp);
                end
                idx++;
                cyc = 0;
                if (idx < 4) begin
                    sm32 = sms[idx];
                    a32 = xs[idx];
                    b32 = ys[idx];
                end else begin
                    start32 = 1'b0;
                end
            end
        end
        start32 = 1'b0;
        tests++;
        if (idx != 4) begin
            fails++;
            $display("FAIL b2b_timeout got %0d results want 4", idx);
        end
        @(posedge clk);
        #1;
        tests++;
        if (busy32 !== 1'b0 || done32 !== 1'b0) begin
            fails++;
            $display("FAIL b2b_idle got busy=%b done=%b want 0 0", busy32, done32);
        end
    endtask

    task automatic test_reset_abort;
        int lat;
        int seen;
        logic [63:0] exp;
        run32(1'b1, 32'h12345678, 32'hFFFFFF00, lat);
        @(negedge clk);
        sm32 = 1'b0;
        a32 = 32'hDEADBEEF;
        b32 = 32'h00C0FFEE;
        start32 = 1'b1;
        @(posedge clk);
        #1;
        start32 = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy32, done32, hi32, lo32} !== 66'b0) begin
            fails++;
            $display("FAIL abort_outputs got busy=%b done=%b hi=%h lo=%h want all 0",
                     busy32, done32, hi32, lo32);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done32 || busy32) seen++;
        end
        tests++;
        if (seen != 0) begin
            fails++;
            $display("FAIL abort_quiet got %0d active cycles want 0", seen);
        end
        run32(1'b0, 32'hDEADBEEF, 32'h00C0FFEE, lat);
        exp = ref_prod(1'b0, 32'hDEADBEEF, 32'h00C0FFEE, 32);
        tests++;
        if ({hi32, lo32} !== exp || lat != 33) begin
            fails++;
            $display("FAIL abort_recover got %h_%h lat=%0d want %h lat=33",
                     hi32, lo32, lat, exp);
        end
    endtask

    task automatic test_sweep8;
        logic        sm;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [63:0] exp;
        int lat;
        int bad_lat;
        int bad_val;
        bad_lat = 0;
        bad_val = 0;
        for (int i = 0; i < 1000; i++) begin
            sm = 1'($urandom);
            x = 8'($urandom);
            y = 8'($urandom);
            if (i < 4) begin
                x = (i[0]) ? 8'h80 : 8'hFF;
                y = (i[1]) ? 8'h80 : 8'hFF;
            end
            run8(sm, x, y, lat);
            exp = ref_prod(sm, {24'b0, x}, {24'b0, y}, 8);
            tests++;
            if (lat != 9) begin
                fails++;
                if (bad_lat++ < 5)
                    $display("FAIL sweep8_latency got %0d want 9", lat);
            end
            tests++;
            if ({hi8, lo8} !== exp[15:0]) begin
                fails++;
                if (bad_val++ < 5)
                    $display("FAIL sweep8_product sm=%b %h*%h got %h_%h want %h",
                             sm, x, y, hi8, lo8, exp[15:0]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        start32 = 1'b0;
        sm32 = 1'b0;
        a32 = '0;
        b32 = '0;
        start8 = 1'b0;
        sm8 = 1'b0;
        a8 = '0;
        b8 = '0;
        test_reset();
        test_corners();
        test_back_to_back();
        test_reset_abort();
        test_sweep8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_mult_seq.md
# booth_mult_seq

Sequential, parametrised radix-2 Booth multiplier for the datapath's MULT/MULTU instructions. Accepts two WIDTH-bit operands on a start pulse, performs one Booth step per clock, and returns the 2·WIDTH-bit product split into hi/lo registers with a one-cycle done pulse. It sits beside the ALU and is driven by the control unit, which stalls on busy. It supersedes the single-width, signed-only multiplier with a handshaked, width-generic, signed/unsigned unit.

## Interface
- WIDTH, 32, operand width; product is 2·WIDTH bits (WIDTH ≥ 4)
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start
- operand1  in  WIDTH  multiplicand; sampled with start
- operand2  in  WIDTH  multiplier; sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse when hi/lo hold a new result
- hi  out  WIDTH  product[2·WIDTH-1:WIDTH]
- lo  out  WIDTH  product[WIDTH-1:0]

## Operation
- Internal operand width W1 = WIDTH+1: operands sign-extended when signed_mode=1, zero-extended otherwise; unsigned and signed share one Booth datapath.
- Registers: A = {m, 0…} and S = {−m mod 2^W1, 0…} (W1 high bits, W1+1 zero low bits); P = {W1 zeros, q, 1'b0}, width 2·W1+1; step counter 0..W1.
- Booth step on P[1:0]: 01 → P+A, 10 → P+S, 00/11 → no add; then arithmetic shift right by 1 (P MSB replicated). Additions wrap modulo 2^(2·W1+1).
- After W1 steps, result = P[2·WIDTH:1] (low 2·WIDTH bits of the product).
- States: IDLE → (start) RUN → (counter = W1−1 step taken) DONE → IDLE, or DONE → (start) RUN directly.
- start during RUN ignored; operand/mode changes during RUN have no effect.
- hi/lo change only on entry to DONE; they hold the last result otherwise.

## Timing
- Reset (asynchronous assert, any state): state IDLE, busy=0, done=0, hi=0, lo=0, P/A/S/counter=0. Reset during RUN aborts; no done pulse follows.
- Edge E0: start sampled high in IDLE/DONE → operands latched, state RUN, busy=1 after E0.
- Edges E1..E(W1): one Booth step each. At E(W1): hi/lo written, state DONE, busy=0, done=1.
- Edge E(W1+1): done=0; state IDLE, or RUN if start is high (back-to-back).
- Latency start-edge to done-high: W1 = WIDTH+1 cycles (33 for WIDTH=32); throughput one product per WIDTH+2 cycles.
- done and busy never high together.

## Structure
- Package mult_pkg: state enum (IDLE, RUN, DONE); helper function for W1 and counter width ($clog2(W1+1)).
- Sub-module booth_step (combinational, parameter PW = 2·W1+1): inputs P, A, S; output next P. Top holds FSM, counter, and registers.

## Test plan
- WIDTH=32, signed, 7 × −3 → done after 33 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- Signed 0x80000000 × 0x80000000 → hi=0x40000000, lo=0x00000000; unsigned same operands → hi=0x40000000, lo=0x00000000; signed −1 × −1 → hi=0, lo=1.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; signed same → hi=0, lo=1.
- start held high continuously with new operands each DONE → back-to-back results every 34 cycles, each correct; start pulses and operand changes during RUN ignored.
- Reset asserted at step 10 of a run → outputs zero immediately, no done pulse; next start yields a correct product.
- WIDTH=8 random signed/unsigned sweep (≥1000 vectors) against reference model; done latency 9 cycles.
